// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a multi-digit seven-segment display.
//            Scans one digit per slot. Each slot opens with a blanking gap to
//            avoid ghosting. Display data is double-buffered and is only
//            committed at a frame boundary, so a frame never shows a mix of
//            old and new data.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_CNT   = 16,
  parameter int BLANK_CNT  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  update,
  output logic [DIGITS-1:0]     io_sel,
  output logic [7:0]            io_seg,
  output logic                  frame_pulse
);

  localparam int CNT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_CNT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W:0]    BLANK_LEN = (CNT_W + 1)'(BLANK_CNT);
  localparam logic              INV       = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{INV}};
  localparam logic [7:0]        SEG_OFF   = {8{INV}};
  localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);

  // Hex digit to segments a..g, active-high, bit 0 = a.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] stage_hex_q, stage_hex_d;
  logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [4*DIGITS-1:0] shadow_hex_q, shadow_hex_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                slot_end;
  logic                wrap;
  logic                blank;
  logic [3:0]          cur_digit;
  logic                cur_dp;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign wrap      = slot_end && (idx_q == IDX_LAST);
  assign blank     = ({1'b0, cnt_q} < BLANK_LEN);
  assign cur_digit = shadow_hex_q[{idx_q, 2'b00} +: 4];
  assign cur_dp    = shadow_dp_q[idx_q];

  // Slot / digit counters: cnt wraps every slot, idx advances on each slot end.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: staging takes every update, shadow only changes on the
  // frame wrap; an update landing on the wrap itself bypasses to shadow.
  always_comb begin
    stage_hex_d  = stage_hex_q;
    stage_dp_d   = stage_dp_q;
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    if (update) begin
      stage_hex_d = hex;
      stage_dp_d  = dp;
      pending_d   = 1'b1;
    end
    if (wrap) begin
      if (update) begin
        shadow_hex_d = hex;
        shadow_dp_d  = dp;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        shadow_hex_d = stage_hex_q;
        shadow_dp_d  = stage_dp_q;
        pending_d    = 1'b0;
      end
    end
  end

  // Pin values for the current counter state, registered one clock later.
  always_comb begin
    sel_d   = SEL_OFF;
    seg_d   = SEG_OFF;
    frame_d = (cnt_q == '0) && (idx_q == '0);
    if (!blank) begin
      sel_d = (SEL_ONE << idx_q) ^ SEL_OFF;
      seg_d = {cur_dp, decode(cur_digit)} ^ SEG_OFF;
    end
  end

  // State and output registers; reset blanks the pins without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_hex_q  <= '0;
      stage_dp_q   <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      sel_q        <= SEL_OFF;
      seg_q        <= SEG_OFF;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_hex_q  <= stage_hex_d;
      stage_dp_q   <= stage_dp_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
    end
  end

  assign io_sel      = sel_q;
  assign io_seg      = seg_q;
  assign frame_pulse = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed, table-driven bench for seg7_scan_driver at defaults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hex;
  logic [3:0]  dp;
  logic        update;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        frame_pulse;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_CNT(16), .BLANK_CNT(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hex(hex), .dp(dp), .update(update),
    .io_sel(io_sel), .io_seg(io_seg), .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  // One vector: updates applied during a frame, expected segments of the frame after.
  typedef struct {
    logic [15:0]     hex;
    logic [3:0]      dp;
    int              off;
    logic [15:0]     hex2;
    logic [3:0]      dp2;
    int              off2;
    logic [3:0][7:0] exp;   // {digit3, digit2, digit1, digit0}, pin level
    string           name;
  } vec_t;

  vec_t vecs[6];

  task automatic check_pins(input string name, input logic efp,
                            input logic [3:0] esel, input logic [7:0] eseg);
    checks++;
    if (frame_pulse !== efp || io_sel !== esel || io_seg !== eseg) begin
      errors++;
      $display("FAIL %s: got fp=%b sel=%b seg=%h, want fp=%b sel=%b seg=%h",
               name, frame_pulse, io_sel, io_seg, efp, esel, eseg);
    end
  endtask

  // Checks all 64 pin cycles of one frame; caller is at the negedge of offset 0.
  // Optional update pulses are driven at the given frame offsets.
  task automatic check_frame(input logic [3:0][7:0] exp, input string name,
                             input int off, input logic [15:0] h, input logic [3:0] d,
                             input int off2, input logic [15:0] h2, input logic [3:0] d2);
    logic [3:0] esel;
    logic [7:0] eseg;
    int k, c;
    for (int o = 0; o < 64; o++) begin
      if (o != 0) @(negedge clk);
      update = 1'b0;
      k = o / 16;
      c = o % 16;
      if (c < 2) begin
        esel = 4'hF;
        eseg = 8'hFF;
      end else begin
        esel = 4'b0001 << k;
        esel = ~esel;
        eseg = exp[k];
      end
      check_pins($sformatf("%s off%0d", name, o), (o == 0), esel, eseg);
      if (o == off) begin
        hex = h; dp = d; update = 1'b1;
      end else if (o == off2) begin
        hex = h2; dp = d2; update = 1'b1;
      end
    end
    @(negedge clk);
    update = 1'b0;
  endtask

  initial begin
    logic [3:0][7:0] zeros;
    zeros  = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
    rst_n  = 1'b0;
    hex    = '0;
    dp     = '0;
    update = 1'b0;

    vecs[0] = '{16'h1234, 4'b0001, 5,  16'h0, 4'h0, -1,
                {8'hF9, 8'hA4, 8'hB0, 8'h19}, "show1234"};
    vecs[1] = '{16'hFFFF, 4'b0000, 20, 16'h0, 4'h0, -1,
                {8'h8E, 8'h8E, 8'h8E, 8'h8E}, "midframeFFFF"};
    vecs[2] = '{16'hABCD, 4'b0000, 62, 16'h0, 4'h0, -1,
                {8'h88, 8'h83, 8'hC6, 8'hA1}, "wrapbypassABCD"};
    vecs[3] = '{16'h5678, 4'b1010, 63, 16'h0, 4'h0, -1,
                {8'h88, 8'h83, 8'hC6, 8'hA1}, "afterwrapheld"};
    vecs[4] = '{16'h0,    4'b0000, -1, 16'h0, 4'h0, -1,
                {8'h12, 8'h82, 8'h78, 8'h80}, "show5678"};
    vecs[5] = '{16'h0000, 4'b0000, 10, 16'h9E0F, 4'b0100, 40,
                {8'h90, 8'h06, 8'hC0, 8'h8E}, "lastwritewins"};

    // Reset held: pins inactive throughout.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_pins($sformatf("reset hold %0d", i), 1'b0, 4'hF, 8'hFF);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);

    // First frame shows "0000"; table vector 0's update is applied in it.
    check_frame(zeros, "frame0", vecs[0].off, vecs[0].hex, vecs[0].dp,
                vecs[0].off2, vecs[0].hex2, vecs[0].dp2);
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < 6)
        check_frame(vecs[i].exp, vecs[i].name, vecs[i+1].off, vecs[i+1].hex,
                    vecs[i+1].dp, vecs[i+1].off2, vecs[i+1].hex2, vecs[i+1].dp2);
      else
        check_frame(vecs[i].exp, vecs[i].name, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    end

    // Leave an update pending, then reset asynchronously during digit 2 drive.
    for (int o = 1; o <= 40; o++) begin
      @(negedge clk);
      update = 1'b0;
      if (o == 30) begin
        hex = 16'h1111; dp = 4'b1111; update = 1'b1;
      end
    end
    check_pins("pre-reset digit2 drive", 1'b0, 4'b1011, 8'h06);
    #2 rst_n = 1'b0;
    #1 check_pins("async reset immediate", 1'b0, 4'hF, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_pins($sformatf("midrun reset hold %0d", i), 1'b0, 4'hF, 8'hFF);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_frame(zeros, "after midrun reset", -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
